// File: rtl/otp_pkg.sv
// otp_pkg: shared FSM state type, default feedback taps and bit-reverse helper for the keystream generator
package otp_pkg;
  typedef enum logic {GEN, HOLD} ks_state_t;
  localparam logic [7:0] DEF_TAPS = 8'hC0;
  function automatic logic [63:0] bit_rev(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/otp_lfsr_core.sv
// otp_lfsr_core: Fibonacci LFSR register with seed load, zero-seed fixup and left/right step
// Ports: clk, clear_n (async active-low reset), i_load/i_seed (seed strobe and value),
//        i_step (advance one bit), i_dir (0 left, 1 right), o_state (register),
//        o_bit (bit shifted out by the current step), o_seed_zero (loaded seed was zero)
module otp_lfsr_core import otp_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_step,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_state,
  output logic             o_bit,
  output logic             o_seed_zero
);
  localparam logic [WIDTH-1:0] RTAPS = WIDTH'(bit_rev(64'(TAPS), WIDTH));
  logic [WIDTH-1:0] r_lfsr;
  logic             w_fb;
  assign w_fb        = i_dir ? ^(r_lfsr & RTAPS) : ^(r_lfsr & TAPS);
  assign o_bit       = i_dir ? r_lfsr[0] : r_lfsr[WIDTH-1];
  assign o_state     = r_lfsr;
  assign o_seed_zero = i_load && i_seed == '0;
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_lfsr <= '1;
    else if (i_load) r_lfsr <= o_seed_zero ? '1 : i_seed;
    else if (i_step) r_lfsr <= i_dir ? {w_fb, r_lfsr[WIDTH-1:1]} : {r_lfsr[WIDTH-2:0], w_fb};
  end
endmodule

// File: rtl/otp_keystream_gen.sv
// otp_keystream_gen: LFSR keystream generator with seed loading and a valid/ready word port
// Ports: clk, clear_n (async active-low reset), seed_load/seed, dir (0 left, 1 right),
//        ks_valid/ks_ready/ks_data (keystream word handshake), lfsr_state, word_cnt
//        (words accepted since reset/seed), seed_zero (zero seed replaced by all-ones).
// Build option OTP_KS_XOR_EN: adds pt_data and outputs word ^ pt_data (OTP enc/dec).
module otp_keystream_gen import otp_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_TAPS),
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             dir,
`ifdef OTP_KS_XOR_EN
  input  logic [OUT_W-1:0] pt_data,
`endif
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [OUT_W-1:0] ks_data,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seed_zero
);
  localparam int CW = OUT_W > 1 ? $clog2(OUT_W) : 1;
  ks_state_t        r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [OUT_W-1:0] r_word;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_dir, r_seed_zero;
  logic             w_step, w_dir, w_bit, w_last, w_zero;
  assign w_last = r_cnt == CW'(OUT_W - 1);
  assign w_step = r_state == GEN && !seed_load;
  // direction is sampled on the first step of a word and held for the rest of it
  assign w_dir  = r_cnt == '0 ? dir : r_dir;
  otp_lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
    .clk(clk), .clear_n(clear_n), .i_load(seed_load), .i_seed(seed), .i_step(w_step),
    .i_dir(w_dir), .o_state(lfsr_state), .o_bit(w_bit), .o_seed_zero(w_zero)
  );
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) r_state <= GEN;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    if (seed_load) w_state_nxt = GEN;
    else if (r_state == GEN) w_state_nxt = w_last ? HOLD : GEN;
    else w_state_nxt = ks_ready ? GEN : HOLD;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_cnt       <= '0;
      r_word      <= '0;
      r_wcnt      <= '0;
      r_dir       <= 1'b0;
      r_seed_zero <= 1'b0;
    end else begin
      r_seed_zero <= w_zero;
      if (seed_load) begin
        r_cnt  <= '0;
        r_word <= '0;
        r_wcnt <= '0;
      end else begin
        if (w_step) begin
          r_word <= OUT_W'({r_word, w_bit});
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          if (r_cnt == '0) r_dir <= dir;
        end
        if (r_state == HOLD && ks_ready) r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end
  assign ks_valid  = r_state == HOLD;
  assign word_cnt  = r_wcnt;
  assign seed_zero = r_seed_zero;
`ifdef OTP_KS_XOR_EN
  assign ks_data = r_word ^ pt_data;
`else
  assign ks_data = r_word;
`endif
endmodule

// File: tb/tb_otp_keystream_gen.sv
// tb_otp_keystream_gen: directed and randomized checks of the keystream generator against a word-level model
module tb_otp_keystream_gen;
  localparam logic [7:0] TAPS = 8'hC0;
  logic       clk = 1'b0, clear_n = 1'b1, seed_load = 1'b0, dir = 1'b0, ks_ready = 1'b0;
  logic [7:0] seed = 8'h00, pt_data = 8'h00;
  logic       ks_valid, seed_zero;
  logic [7:0] ks_data, lfsr_state;
  logic [3:0] word_cnt;
  int errors = 0, checks = 0;
  logic [7:0] m_s, w, d0, l0;
  logic [3:0] m_cnt;
  logic       rd;
  always #5 clk = ~clk;
  otp_keystream_gen #(.WIDTH(8), .TAPS(TAPS), .OUT_W(8), .CNT_W(4)) dut (
    .clk(clk), .clear_n(clear_n), .seed_load(seed_load), .seed(seed), .dir(dir),
`ifdef OTP_KS_XOR_EN
    .pt_data(pt_data),
`endif
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .lfsr_state(lfsr_state), .word_cnt(word_cnt), .seed_zero(seed_zero)
  );
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction
  function automatic logic [7:0] lstep(input logic [7:0] v);
    return 8'((v * 2) % 256 + ($countones(v & TAPS) % 2));
  endfunction
  // a right-shifting LFSR is the mirror image of the left-shifting one
  task automatic model_word(input logic d, output logic [7:0] wd);
    logic b;
    wd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = d ? m_s[0] : m_s[7];
      m_s = d ? rev8(lstep(rev8(m_s))) : lstep(m_s);
      wd = {wd[6:0], b};
    end
  endtask
  function automatic logic [7:0] exp_data(input logic [7:0] wd);
`ifdef OTP_KS_XOR_EN
    return wd ^ pt_data;
`else
    return wd;
`endif
  endfunction
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (ks_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("valid_wait", 16'(ks_valid), 16'd1);
  endtask
  task automatic do_seed(input logic [7:0] s, input logic d, input logic r);
    seed = s; dir = d; seed_load = 1'b1; ks_ready = r;
    @(negedge clk);
    seed_load = 1'b0; ks_ready = 1'b0;
    m_s = s == 8'h00 ? 8'hFF : s;
    m_cnt = 4'd0;
    chk("seed_lfsr", 16'(lfsr_state), 16'(m_s));
    chk("seed_cnt", 16'(word_cnt), 16'd0);
    chk("seed_zero", 16'(seed_zero), 16'(s == 8'h00));
    chk("seed_valid", 16'(ks_valid), 16'd0);
  endtask
  task automatic accept();
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    m_cnt++;
    chk("acc_cnt", 16'(word_cnt), 16'(m_cnt));
    chk("acc_valid", 16'(ks_valid), 16'd0);
  endtask
  initial begin
    #1 clear_n = 1'b0;
    #1;
    chk("rst_valid", 16'(ks_valid), 16'd0);
    chk("rst_data", 16'(ks_data), 16'd0);
    chk("rst_lfsr", 16'(lfsr_state), 16'hFF);
    chk("rst_cnt", 16'(word_cnt), 16'd0);
    chk("rst_zero", 16'(seed_zero), 16'd0);
    @(negedge clk);
    clear_n = 1'b1;
    m_s = 8'hFF; m_cnt = 4'd0;
    repeat (7) @(negedge clk);
    chk("t1_latency", 16'(ks_valid), 16'd0);
    @(negedge clk);
    chk("t1_valid", 16'(ks_valid), 16'd1);
    model_word(1'b0, w);
    chk("t1_data", 16'(ks_data), 16'hFF);
    chk("t1_model", 16'(ks_data), 16'(exp_data(w)));
    chk("t1_lfsr", 16'(lfsr_state), 16'h01);
    accept();
    do_seed(8'h01, 1'b0, 1'b0);
    wait_valid();
    model_word(1'b0, w);
    chk("t2_data", 16'(ks_data), 16'h01);
    chk("t2_lfsr", 16'(lfsr_state), 16'h03);
    chk("t2_model", 16'(ks_data), 16'(exp_data(w)));
    accept();
    do_seed(8'h80, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    dir = 1'b0;
    wait_valid();
    model_word(1'b1, w);
    chk("t3_data", 16'(ks_data), 16'h01);
    chk("t3_lfsr", 16'(lfsr_state), 16'hC0);
    chk("t3_model", 16'(ks_data), 16'(exp_data(w)));
    do_seed(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_pulse_end", 16'(seed_zero), 16'd0);
    wait_valid();
    model_word(1'b0, w);
    chk("t4_data", 16'(ks_data), 16'(exp_data(w)));
    accept();
    wait_valid();
    model_word(1'b0, w);
    d0 = ks_data; l0 = lfsr_state;
    chk("t5_data", 16'(d0), 16'(exp_data(w)));
    repeat (20) @(negedge clk);
    chk("t5_hold_valid", 16'(ks_valid), 16'd1);
    chk("t5_hold_data", 16'(ks_data), 16'(d0));
    chk("t5_hold_lfsr", 16'(lfsr_state), 16'(l0));
    do_seed(8'(($urandom % 255) + 1), 1'b1, 1'b1);
    wait_valid();
    model_word(1'b1, w);
    chk("t5_reseed_data", 16'(ks_data), 16'(exp_data(w)));
    chk("t5_reseed_lfsr", 16'(lfsr_state), 16'(m_s));
    do_seed(8'h5A, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    clear_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(ks_valid), 16'd0);
    chk("mid_rst_data", 16'(ks_data), 16'd0);
    chk("mid_rst_lfsr", 16'(lfsr_state), 16'hFF);
    @(negedge clk);
    clear_n = 1'b1; dir = 1'b1;
    m_s = 8'hFF; m_cnt = 4'd0;
    wait_valid();
    model_word(1'b1, w);
    chk("mid_rst_word", 16'(ks_data), 16'(exp_data(w)));
    do_seed(8'($urandom), 1'($urandom), 1'b0);
    rd = dir;
    for (int k = 0; k < 20; k++) begin
      wait_valid();
      model_word(rd, w);
      chk("rnd_data", 16'(ks_data), 16'(exp_data(w)));
      chk("rnd_lfsr", 16'(lfsr_state), 16'(m_s));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
      rd = 1'($urandom);
      dir = rd;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
